// File: rtl/pwm_mixer_nch.sv
// NCH-channel PWM generator whose duty registers are stepped by debounced inc/dec buttons.
// Define PWM_AUTOREPEAT_EN to add auto-repeat of a held button.
module pwm_mixer_nch #(
    parameter int CLK_FREQ      = 50000000,
    parameter int PWM_FREQ      = 10000,
    parameter int DEBOUNCE_FREQ = 1000000,
    parameter int NCH           = 3,
    parameter int DUTY_W        = 8,
    parameter int STEP          = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    localparam int SEL_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     dec,
    input  logic [SEL_W-1:0]         sel,
    output logic [NCH-1:0]           pwm,
    output logic [NCH*DUTY_W-1:0]    duty_o
);

    localparam int PERIOD = CLK_FREQ / PWM_FREQ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DB_DIV = CLK_FREQ / DEBOUNCE_FREQ;
    localparam int DB_W   = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
    localparam int PROD_W = DUTY_W + $clog2(PERIOD + 1);
    localparam int SUM_W  = DUTY_W + 32;
    localparam logic [DUTY_W-1:0] FULL = '1;

    if (NCH < 1 || DUTY_W < 1 || PERIOD < 2 || DB_DIV < 1 || STEP < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("pwm_mixer_nch: invalid parameter set");
    end

    function automatic logic [DUTY_W-1:0] sat_inc(input logic [DUTY_W-1:0] d);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(d) + SUM_W'(STEP);
        return (sum >= SUM_W'(FULL)) ? FULL : sum[DUTY_W-1:0];
    endfunction

    function automatic logic [DUTY_W-1:0] sat_dec(input logic [DUTY_W-1:0] d);
        return (SUM_W'(d) <= SUM_W'(STEP)) ? '0 : d - DUTY_W'(STEP);
    endfunction

    function automatic logic pwm_level(input logic [DUTY_W-1:0] act, input logic [CNT_W-1:0] c);
        logic [PROD_W-1:0] thr;
        thr = (PROD_W'(act) * PROD_W'(PERIOD)) >> DUTY_W;
        if (act == '0)
            return 1'b0;
        if (act == FULL)
            return 1'b1;
        return PROD_W'(c) < thr;
    endfunction

    // Button front end: bit 0 = inc, bit 1 = dec
    logic [1:0]      raw, sync_p0, sync_p1, clean, clean_d, press, cmd;
    logic [1:0]      run [2];
    logic [DB_W-1:0] db_cnt;
    logic            tick;

    assign raw   = {dec, inc};
    assign tick  = (db_cnt == DB_W'(DB_DIV - 1));
    assign press = clean & ~clean_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            clean   <= '0;
            clean_d <= '0;
            db_cnt  <= '0;
            run[0]  <= '0;
            run[1]  <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            clean_d <= clean;
            db_cnt  <= tick ? '0 : db_cnt + 1'b1;
            if (tick) begin
                for (int b = 0; b < 2; b++) begin
                    if (sync_p1[b] == clean[b]) begin
                        run[b] <= '0;
                    end else if (run[b] == 2'd2) begin
                        clean[b] <= sync_p1[b];
                        run[b]   <= '0;
                    end else begin
                        run[b] <= run[b] + 2'd1;
                    end
                end
            end
        end
    end

`ifdef PWM_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt [2];
    logic [1:0]       rep_on, rep_armed, rep_fire;
    logic [SEL_W-1:0] sel_d;

    // A channel switch during a hold cancels the repeat until the next press
    always_comb begin
        rep_fire = '0;
        for (int b = 0; b < 2; b++) begin
            rep_fire[b] = rep_on[b] && clean[b] && (sel == sel_d) &&
                          (rep_cnt[b] == (rep_armed[b] ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_d     <= '0;
            rep_on    <= '0;
            rep_armed <= '0;
            rep_cnt[0] <= '0;
            rep_cnt[1] <= '0;
        end else begin
            sel_d <= sel;
            for (int b = 0; b < 2; b++) begin
                if (!clean[b]) begin
                    rep_on[b]    <= 1'b0;
                    rep_armed[b] <= 1'b0;
                    rep_cnt[b]   <= '0;
                end else if (press[b]) begin
                    rep_on[b]    <= 1'b1;
                    rep_armed[b] <= 1'b0;
                    rep_cnt[b]   <= REP_W'(1);
                end else if (sel != sel_d) begin
                    rep_on[b]    <= 1'b0;
                    rep_armed[b] <= 1'b0;
                    rep_cnt[b]   <= '0;
                end else if (rep_fire[b]) begin
                    rep_armed[b] <= 1'b1;
                    rep_cnt[b]   <= REP_W'(1);
                end else if (rep_on[b]) begin
                    rep_cnt[b] <= rep_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign cmd = press | rep_fire;
`else
    assign cmd = press;
`endif

    logic [DUTY_W-1:0] duty   [NCH];
    logic [DUTY_W-1:0] active [NCH];
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              wrap;

    assign wrap    = (cnt == CNT_W'(PERIOD - 1));
    assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

    // pwm is computed from next-cycle counter/active so it lines up with the counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            pwm <= '0;
            for (int i = 0; i < NCH; i++) begin
                duty[i]   <= '0;
                active[i] <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            for (int i = 0; i < NCH; i++) begin
                if (sel == SEL_W'(i)) begin
                    if (cmd[0] && !cmd[1])
                        duty[i] <= sat_inc(duty[i]);
                    else if (cmd[1] && !cmd[0])
                        duty[i] <= sat_dec(duty[i]);
                end
                if (wrap)
                    active[i] <= duty[i];
                pwm[i] <= pwm_level(wrap ? duty[i] : active[i], cnt_nxt);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_readback
        assign duty_o[g*DUTY_W +: DUTY_W] = duty[g];
    end

endmodule

// File: tb/tb_pwm_mixer_nch.sv
// Scoreboard bench for pwm_mixer_nch: duty_o changes are matched against a queue of
// expected readbacks, pwm is compared every cycle against a per-period model.
module tb_pwm_mixer_nch;

    localparam int NCH    = 3;
    localparam int DUTY_W = 8;
    localparam int STEP   = 16;
    localparam int PERIOD = 100;
    localparam int FULL   = 255;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  inc = 1'b0;
    logic                  dec = 1'b0;
    logic [1:0]            sel = 2'd0;
    logic [NCH-1:0]        pwm;
    logic [NCH*DUTY_W-1:0] duty_o;

    pwm_mixer_nch #(
        .CLK_FREQ(1000), .PWM_FREQ(10), .DEBOUNCE_FREQ(500), .NCH(NCH),
        .DUTY_W(DUTY_W), .STEP(STEP), .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
    ) dut (
        .clk(clk), .rst(rst), .inc(inc), .dec(dec), .sel(sel), .pwm(pwm), .duty_o(duty_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [NCH*DUTY_W-1:0] sb [$];
    logic [NCH*DUTY_W-1:0] last_duty = '0;
    logic [NCH*DUTY_W-1:0] exp_vec;
    int exp_duty [NCH];   // model duty as of the commands issued so far
    int cur_duty [NCH];   // model duty as of the last readback change
    int act      [NCH];   // model shadow duty of the running period
    int ph = 0;           // model period counter
    int edges = 0;        // clock edges since reset release

    task automatic check(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [NCH*DUTY_W-1:0] pack_duty();
        logic [NCH*DUTY_W-1:0] v = '0;
        for (int c = 0; c < NCH; c++) v[c*DUTY_W +: DUTY_W] = DUTY_W'(exp_duty[c]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_pwm();
        logic [NCH-1:0] v = '0;
        if (rst) return '0;
        for (int c = 0; c < NCH; c++) begin
            if (act[c] == FULL) v[c] = 1'b1;
            else if (act[c] != 0 && ph < (act[c] * PERIOD) / (1 << DUTY_W)) v[c] = 1'b1;
        end
        return v;
    endfunction

    // One command on channel s; only a real change of the readback is expected
    task automatic apply_cmd(input int s, input bit up, input bit dn);
        int nv;
        if (s >= NCH || up == dn) return;
        nv = up ? exp_duty[s] + STEP : exp_duty[s] - STEP;
        if (nv > FULL) nv = FULL;
        if (nv < 0) nv = 0;
        if (nv != exp_duty[s]) begin
            exp_duty[s] = nv;
            sb.push_back(pack_duty());
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // kind: 0 = inc, 1 = dec, 2 = both together
    task automatic press(input int kind, input int hold);
        apply_cmd(int'(sel), kind != 1, kind != 0);
        inc = (kind != 1);
        dec = (kind != 0);
        cycles(hold);
        inc = 1'b0;
        dec = 1'b0;
        cycles(16);
    endtask

    // Glitches land between debounce samples, so no three samples agree on high
    task automatic bounce();
        while (edges % 2 != 0) cycles(1);
        for (int k = 0; k < 5; k++) begin
            inc = (k % 2 == 0);
            cycles(1);
        end
        inc = 1'b0;
        cycles(16);
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            cycles(1);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic count_high(input int c, output int hi);
        hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            hi += int'(pwm[c]);
        end
        cycles(1);
    endtask

    // Reference period counter and shadow duty
    initial forever begin
        @(posedge clk);
        if (rst) begin
            ph = 0;
            edges = 0;
            for (int c = 0; c < NCH; c++) act[c] = 0;
        end else begin
            edges++;
            if (ph == PERIOD - 1) begin
                ph = 0;
                for (int c = 0; c < NCH; c++) act[c] = cur_duty[c];
            end else begin
                ph++;
            end
        end
    end

    // Monitor: pop on every readback change, and check pwm each cycle
    initial forever begin
        @(negedge clk);
        if (duty_o !== last_duty) begin
            if (sb.size() == 0) begin
                check("duty_spurious", duty_o, last_duty);
            end else begin
                exp_vec = sb.pop_front();
                check("duty_o", duty_o, exp_vec);
                for (int c = 0; c < NCH; c++) cur_duty[c] = int'(exp_vec[c*DUTY_W +: DUTY_W]);
            end
            last_duty = duty_o;
        end
        check("pwm", pwm, exp_pwm());
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int nrep;
        int n;
        for (int c = 0; c < NCH; c++) begin
            exp_duty[c] = 0;
            cur_duty[c] = 0;
            act[c] = 0;
        end
        cycles(3);
        check("reset_pwm", pwm, 0);
        check("reset_duty_o", duty_o, 0);
        rst = 1'b0;
        cycles(4);

        // Single inc on ch1 landing mid-period; new duty only shows from next period
        sel = 2'd1;
        while (ph != 42) cycles(1);
        press(0, 12);
        drain("ch1_inc", 50);
        while (ph != 0) cycles(1);
        count_high(1, hi);
        check("ch1_high_cycles", hi, 6);

        // Saturate ch0 upward then downward
        sel = 2'd0;
        for (int k = 0; k < 17; k++) press(0, 12);
        drain("ch0_inc_sat", 50);
        cycles(PERIOD);
        while (ph != 0) cycles(1);
        count_high(0, hi);
        check("ch0_full_high", hi, PERIOD);
        for (int k = 0; k < 20; k++) press(1, 12);
        drain("ch0_dec_sat", 50);
        cycles(PERIOD);
        while (ph != 0) cycles(1);
        count_high(0, hi);
        check("ch0_zero_high", hi, 0);

        // Commands that must not change anything
        sel = 2'd1;
        bounce();
        press(2, 12);
        sel = 2'd3;
        press(0, 12);
        cycles(10);
        check("noop_duty", duty_o, pack_duty());

        // Randomised command mix
        for (int r = 0; r < 16; r++) begin
            sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: press(0, $urandom_range(10, 20));
                1: press(1, $urandom_range(10, 20));
                2: press(2, $urandom_range(10, 20));
                default: bounce();
            endcase
            cycles($urandom_range(1, 8));
        end
        drain("random_mix", 50);

        // Asynchronous reset in the high part of a period
        sel = 2'd1;
        press(0, 12);
        drain("pre_reset_inc", 50);
        cycles(PERIOD);
        while (ph != 2) cycles(1);
        check("pre_reset_pwm1", pwm[1], 1);
        if (pack_duty() != '0) begin
            for (int c = 0; c < NCH; c++) exp_duty[c] = 0;
            sb.push_back(pack_duty());
        end
        rst = 1'b1;
        #1;
        check("async_reset_pwm", pwm, 0);
        check("async_reset_duty_o", duty_o, 0);
        cycles(3);
        rst = 1'b0;
        cycles(4);
        drain("reset_readback", 10);

        // Long hold on ch2: edge pulse plus any repeats while clean stays high (~103 cycles)
        sel = 2'd2;
`ifdef PWM_AUTOREPEAT_EN
        nrep = (103 - 40) / 10 + 1;
`else
        nrep = 0;
`endif
        for (int k = 0; k <= nrep; k++) apply_cmd(2, 1'b1, 1'b0);
        inc = 1'b1;
        n = 0;
        while (sb.size() > nrep && n < 40) begin
            cycles(1);
            n++;
        end
        check("hold_first_pulse", sb.size(), nrep);
        cycles(96);
        inc = 1'b0;
        cycles(30);
        drain("hold_repeats", 20);
        check("hold_final_ch2", duty_o[2*DUTY_W +: DUTY_W], (nrep + 1) * STEP);

        // Switching channel mid-hold must not carry a repeat over
        apply_cmd(2, 1'b1, 1'b0);
        inc = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            cycles(1);
            n++;
        end
        check("switch_first_pulse", sb.size(), 0);
        cycles(20);
        sel = 2'd0;
        cycles(80);
        inc = 1'b0;
        cycles(30);
        check("switch_no_repeat", duty_o, pack_duty());

        cycles(2 * PERIOD);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_mixer_nch.md
PWM_MIXER_NCH -- requirements
Module: pwm_mixer_nch

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter PWM_FREQ, default 10000, PWM frequency in Hz; PERIOD = CLK_FREQ/PWM_FREQ cycles.
REQ-003 Parameter DEBOUNCE_FREQ, default 1000000, debounce sample rate in Hz; DB_DIV = CLK_FREQ/DEBOUNCE_FREQ cycles.
REQ-004 Parameter NCH, default 3, channel count (>=1); SEL_W = max(1, $clog2(NCH)).
REQ-005 Parameter DUTY_W, default 8, duty register width; FULL = 2^DUTY_W-1.
REQ-006 Parameter STEP, default 1, duty increment/decrement per command.
REQ-007 Parameter REPEAT_DELAY, default 25000000, hold cycles before auto-repeat starts.
REQ-008 Parameter REPEAT_PERIOD, default 5000000, cycles between auto-repeat commands.
REQ-009 clk  input  1  single clock, rising edge.
REQ-010 rst  input  1  reset, asynchronous, active-high.
REQ-011 inc  input  1  raw increment button, asynchronous to clk.
REQ-012 dec  input  1  raw decrement button, asynchronous to clk.
REQ-013 sel  input  SEL_W  selected channel index.
REQ-014 pwm  output  NCH  PWM outputs, bit i = channel i.
REQ-015 duty_o  output  NCH*DUTY_W  duty register readback, channel i at [i*DUTY_W +: DUTY_W].

Function
REQ-016 inc/dec SHALL each pass a 2-flop synchroniser, then be sampled every DB_DIV cycles; the clean level SHALL change only after 3 consecutive samples all differ from it.
REQ-017 Rising edge of a clean level SHALL produce a one-cycle command pulse.
REQ-018 Channel i SHALL be enabled when sel==i; sel>=NCH SHALL enable no channel, and commands are dropped.
REQ-019 An inc pulse SHALL set duty = min(duty+STEP, FULL), saturating with no wrap.
REQ-020 A dec pulse SHALL set duty = max(duty-STEP, 0), saturating with no wrap.
REQ-021 Simultaneous inc and dec pulses SHALL leave duty unchanged.
REQ-022 duty_o SHALL reflect the updated duty register one cycle after the command pulse.
REQ-023 A shared period counter SHALL count 0..PERIOD-1 and wrap to 0.
REQ-024 Each channel SHALL hold an active (shadow) duty, loaded from its duty register only on the cycle the counter wraps to 0.
- Duty changes never glitch a running period.
REQ-025 Compare threshold SHALL be (active*PERIOD)>>DUTY_W, computed at full width without overflow.
REQ-026 pwm[i] SHALL be registered and driven according to the active duty:
- active==0: constant low.
- active==FULL: constant high.
- otherwise: high while counter < threshold.
REQ-027 Changing sel mid-hold SHALL NOT transfer any pending repeat to the new channel until a new hold qualifies.

Reset
REQ-028 While rst is high, all of the following SHALL be 0:
- pwm, duty_o, duty and active registers.
- period and debounce counters.
- clean levels, synchronisers and repeat counters.
REQ-029 Reset asserted mid-period SHALL force pwm low immediately.
REQ-030 After rst deasserts, the counter SHALL start at 0 on the first clock.

Configuration
REQ-031 With PWM_AUTOREPEAT_EN defined, a clean level held high for REPEAT_DELAY cycles after its edge pulse SHALL emit a further pulse, then one every REPEAT_PERIOD cycles until release.
- Repeat pulses obey REQ-019..021 saturation.
REQ-032 Without PWM_AUTOREPEAT_EN, only edge pulses SHALL be generated, and no repeat counters SHALL be synthesised.

Verification
Bench parameters: CLK_FREQ=1000, PWM_FREQ=10 (PERIOD=100), DEBOUNCE_FREQ=500 (DB_DIV=2), NCH=3, DUTY_W=8, STEP=16, REPEAT_DELAY=40, REPEAT_PERIOD=10.
REQ-033 rst pulse mid-run -> pwm=000 and duty_o=0 asynchronously; counter restarts at 0 after release.
REQ-034 sel=1, one clean inc press -> duty ch1=16 and ch0/ch2 unchanged; from next period start, pwm[1] high 6 cycles of 100 ((16*100)>>8=6).
REQ-035 sel=0, 17 inc presses -> duty ch0=255 (saturated) and pwm[0] constant high; then 20 dec presses -> 0 and pwm[0] constant low.
REQ-036 inc bouncing (toggling every cycle) for 5 cycles, then low -> no duty change; inc and dec pressed together -> no change; sel=3 with inc -> no channel changes.
REQ-037 inc pressed at counter=50 -> duty_o updates immediately; pwm waveform unchanged until counter wraps to 0.
REQ-038 With PWM_AUTOREPEAT_EN: inc held 100 cycles after qualification -> duty 16 + 16*7 = 128; without the macro -> 16.
